mem_block_responder: RTL and testbench

Main-memory-side responder for the cache block-transfer interface. It accepts 4-byte block read and write-back commands issued as counted beat strobes on `rd_mem`/`wr_mem`. Read data is returned byte-serially after a programmable access latency, and write-back blocks are committed atomically into a byte-wide backing array. It sits between the cache controller and the memory model or physical memory in the CPU subsystem.

---
 rtl/mem_resp_pkg.sv | 25 ++
 rtl/mem_block_responder_if.sv | 31 +++
 rtl/mem_byte_array.sv | 35 +++
 rtl/mem_block_responder.sv | 201 ++++++++++++++++++++
 tb/tb_mem_block_responder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types and constants for the memory block responder.
//   resp_state_t    - responder FSM states
//   BEATS_PER_BLOCK - beats in one cache block (fixed at 4)
//   BEAT_FIRST/LAST - beat-counter codes marking the first and last beat
//   beat_code()     - beat-counter code expected for a zero-based beat index
package mem_resp_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RLAT    = 3'd1,
    RDATA   = 3'd2,
    WDATA   = 3'd3,
    WCOMMIT = 3'd4
  } resp_state_t;

  localparam int         BEATS_PER_BLOCK = 4;
  localparam logic [3:0] BEAT_FIRST      = 4'd1;
  localparam logic [3:0] BEAT_LAST       = 4'd4;

  // The cache counts beats from 1, so beat index k is tagged with code k+1.
  function automatic logic [3:0] beat_code(input logic [1:0] idx);
    return {2'b00, idx} + BEAT_FIRST;
  endfunction

endpackage

// File: rtl/mem_block_responder_if.sv
// mem_block_responder_if: command/handshake bundle between the cache
// controller (master) and the memory block responder (slave).
//   addr_mem   - block address (low two bits ignored by the responder)
//   rd_mem     - read beat counter, 1 starts a read
//   wr_mem     - write beat counter, 1..4 tag write beats 0..3
//   wmem_byte  - write beat data
//   rvalid_mem - read beat valid on the separate data_mem bus
//   ready_mem  - responder can accept a command or write beat
//   err_mem    - one-cycle protocol-error pulse
interface mem_block_responder_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] addr_mem;
  logic [3:0]        rd_mem;
  logic [3:0]        wr_mem;
  logic [DWIDTH-1:0] wmem_byte;
  logic              rvalid_mem;
  logic              ready_mem;
  logic              err_mem;

  modport master (
    output addr_mem, rd_mem, wr_mem, wmem_byte,
    input  rvalid_mem, ready_mem, err_mem
  );

  modport slave (
    input  addr_mem, rd_mem, wr_mem, wmem_byte,
    output rvalid_mem, ready_mem, err_mem
  );
endinterface

// File: rtl/mem_byte_array.sv
// mem_byte_array: byte-wide backing store, 2**AWIDTH bytes, not reset.
//   clock   - write clock
//   we_i    - commit a whole 4-byte block
//   waddr_i - block base address (low two bits are expected to be zero)
//   wdata_i - block data, byte k at bits [k*DWIDTH +: DWIDTH]
//   raddr_i - byte read address
//   rdata_o - combinational read data
module mem_byte_array
  import mem_resp_pkg::*;
#(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8
) (
  input  logic                  clock,
  input  logic                  we_i,
  input  logic [AWIDTH-1:0]     waddr_i,
  input  logic [4*DWIDTH-1:0]   wdata_i,
  input  logic [AWIDTH-1:0]     raddr_i,
  output logic [DWIDTH-1:0]     rdata_o
);

  logic [DWIDTH-1:0] mem_q [2**AWIDTH];

  // All four bytes of a block land on the same edge so readers never see a partial block.
  always_ff @(posedge clock) begin
    if (we_i) begin
      for (int k = 0; k < BEATS_PER_BLOCK; k++) begin
        mem_q[waddr_i | AWIDTH'(k)] <= wdata_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_block_responder.sv
// mem_block_responder: main-memory-side responder for 4-beat block reads and
// atomic write-backs, with a fixed LATENCY (1..15) access delay.
//   clock, reset_n - clock and asynchronous active-low reset
//   bus            - mem_block_responder_if.slave command/handshake bundle
//   data_mem       - read beat data, driven only while rvalid_mem is high
//   rd_count, wr_count - completed read / commit counters, 16-bit saturating,
//                    present only when MEMRESP_STATS_EN is defined
module mem_block_responder
  import mem_resp_pkg::*;
#(
  parameter int AWIDTH  = 9,
  parameter int DWIDTH  = 8,
  parameter int LATENCY = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  mem_block_responder_if.slave  bus,
  inout  wire  [DWIDTH-1:0]     data_mem
`ifdef MEMRESP_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic [15:0]           wr_count
`endif
);

  localparam logic [3:0]        LAT_LOAD = 4'(LATENCY);
  localparam logic [AWIDTH-1:0] BLK_MASK = {{(AWIDTH-2){1'b1}}, 2'b00};

  resp_state_t         state_q, state_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic [4*DWIDTH-1:0] wbuf_q, wbuf_d;
  logic [1:0]          bcnt_q, bcnt_d;
  logic [1:0]          beat_q, beat_d;
  logic [3:0]          lat_q, lat_d;
  logic [DWIDTH-1:0]   rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                we_s;
  logic [1:0]          rd_idx_s;
  logic [DWIDTH-1:0]   rd_byte_s;
  logic [AWIDTH-1:0]   addr_base_s;

  assign addr_base_s = bus.addr_mem & BLK_MASK;
  // Look one beat ahead so the byte is registered on the edge it becomes visible.
  assign rd_idx_s    = (state_q == RDATA) ? beat_q + 2'd1 : 2'd0;

  mem_byte_array #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH)
  ) u_array (
    .clock   (clock),
    .we_i    (we_s),
    .waddr_i (base_q),
    .wdata_i (wbuf_q),
    .raddr_i (base_q | {{(AWIDTH-2){1'b0}}, rd_idx_s}),
    .rdata_o (rd_byte_s)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    wbuf_d  = wbuf_q;
    bcnt_d  = bcnt_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    we_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.wr_mem == BEAT_FIRST) begin
          // Write wins a simultaneous start; the collision is flagged.
          state_d = WDATA;
          base_d  = addr_base_s;
          wbuf_d  = {{(3*DWIDTH){1'b0}}, bus.wmem_byte};
          bcnt_d  = 2'd1;
          err_d   = (bus.rd_mem == BEAT_FIRST);
        end else if (bus.rd_mem == BEAT_FIRST) begin
          state_d = RLAT;
          base_d  = addr_base_s;
          lat_d   = LAT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      RLAT: begin
        if (lat_q <= 4'd1) begin
          state_d = RDATA;
          lat_d   = 4'd0;
          beat_d  = 2'd0;
          rdata_d = rd_byte_s;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RDATA: begin
        if (beat_q == 2'd3) begin
          state_d = IDLE;
          beat_d  = 2'd0;
        end else begin
          beat_d  = beat_q + 2'd1;
          rdata_d = rd_byte_s;
        end
      end
      WDATA: begin
        if (bus.wr_mem == beat_code(bcnt_q)) begin
          wbuf_d[int'(bcnt_q)*DWIDTH +: DWIDTH] = bus.wmem_byte;
          if (bus.wr_mem == BEAT_LAST) begin
            state_d = WCOMMIT;
            lat_d   = LAT_LOAD;
            bcnt_d  = 2'd0;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end else begin
          // Out-of-sequence beat: drop the partial block, leave the array alone.
          state_d = IDLE;
          wbuf_d  = '0;
          bcnt_d  = 2'd0;
          err_d   = 1'b1;
        end
      end
      WCOMMIT: begin
        if (lat_q <= 4'd1) begin
          we_s    = 1'b1;
          state_d = IDLE;
          lat_d   = 4'd0;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d  = (state_d == IDLE) || (state_d == WDATA);
    rvalid_d = (state_d == RDATA);
  end

  // State and registered-output flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      base_q   <= '0;
      wbuf_q   <= '0;
      bcnt_q   <= 2'd0;
      beat_q   <= 2'd0;
      lat_q    <= 4'd0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      wbuf_q   <= wbuf_d;
      bcnt_q   <= bcnt_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign bus.ready_mem  = ready_q;
  assign bus.rvalid_mem = rvalid_q;
  assign bus.err_mem    = err_q;
  assign data_mem       = rvalid_q ? rdata_q : {DWIDTH{1'bz}};

`ifdef MEMRESP_STATS_EN
  logic        rd_done_s;
  logic [15:0] rd_cnt_q;
  logic [15:0] wr_cnt_q;

  // Beat 3 becomes visible on the edge that leaves beat index 2.
  assign rd_done_s = (state_q == RDATA) && (beat_q == 2'd2);

  // Saturating completion counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      if (rd_done_s && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (we_s && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`endif

endmodule

// File: tb/tb_mem_block_responder.sv
// Self-checking bench for mem_block_responder: a timeline model records the
// expected ready/rvalid/err/data for each cycle from the transaction rules,
// and a byte-array model tracks committed memory contents.
module tb_mem_block_responder;

  localparam int AW  = 9;
  localparam int DW  = 8;
  localparam int LAT = 2;
  localparam int N   = 4096;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  wire [DW-1:0] data_mem;
  mem_block_responder_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
`ifdef MEMRESP_STATS_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  mem_block_responder #(.AWIDTH(AW), .DWIDTH(DW), .LATENCY(LAT)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .bus      (bus),
    .data_mem (data_mem)
`ifdef MEMRESP_STATS_EN
    ,
    .rd_count (rd_count),
    .wr_count (wr_count)
`endif
  );

  int  checks   = 0;
  int  failures = 0;
  int  ec       = 0;
  bit  run      = 1'b0;
  int  last_t   = 0;
  int  m_rd     = 0;
  int  m_wr     = 0;

  // Expected outputs for cycle n (the cycle after rising edge n-1).
  bit         exp_ready [N];
  bit         exp_rv    [N];
  bit         exp_err   [N];
  bit         exp_known [N];
  logic [7:0] exp_data  [N];
  logic       smp_ready [N];
  logic       smp_rv    [N];
  logic       smp_err   [N];
  logic [7:0] smp_data  [N];
  logic [7:0] mm [512];
  bit         mk [512];

  always @(posedge clock) ec <= ec + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, ec);
    end
  endtask

  // Per-cycle comparison against the timeline model.
  always @(negedge clock) begin
    if (run && ec < N) begin
      smp_ready[ec] <= bus.ready_mem;
      smp_rv[ec]    <= bus.rvalid_mem;
      smp_err[ec]   <= bus.err_mem;
      smp_data[ec]  <= data_mem;
      chk("ready_mem", 32'(bus.ready_mem), 32'(exp_ready[ec]));
      chk("rvalid_mem", 32'(bus.rvalid_mem), 32'(exp_rv[ec]));
      chk("err_mem", 32'(bus.err_mem), 32'(exp_err[ec]));
      if (exp_rv[ec] && exp_known[ec]) chk("data_mem", 32'(data_mem), 32'(exp_data[ec]));
    end
  end

  task automatic clear_exp(input int from, input int cnt);
    for (int i = from; i < from + cnt && i < N; i++) begin
      exp_ready[i] = 1'b1;
      exp_rv[i]    = 1'b0;
      exp_err[i]   = 1'b0;
      exp_known[i] = 1'b0;
      exp_data[i]  = 8'h00;
    end
  endtask

  task automatic set_in(input logic [3:0] rd, input logic [3:0] wr, input logic [8:0] a, input logic [7:0] wb);
    bus.rd_mem    = rd;
    bus.wr_mem    = wr;
    bus.addr_mem  = a;
    bus.wmem_byte = wb;
  endtask

  task automatic junk();
    set_in(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 9'($urandom), 8'($urandom));
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    set_in(4'd0, 4'd0, 9'd0, 8'd0);
  endtask

  // Called at a falling edge: reset immediately, hold one cycle, release.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    set_in(4'd0, 4'd0, 9'd0, 8'd0);
    #1;
    chk("rst_ready", 32'(bus.ready_mem), 32'd1);
    chk("rst_rvalid", 32'(bus.rvalid_mem), 32'd0);
    chk("rst_err", 32'(bus.err_mem), 32'd0);
    clear_exp(ec, 40);
    m_rd = 0;
    m_wr = 0;
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic do_read(input logic [8:0] a, input bit rst_b2);
    int t;
    logic [8:0] b;
    b = a & 9'h1FC;
    set_in(4'd1, 4'd0, a, 8'($urandom));
    @(posedge clock);
    t = ec;
    last_t = t;
    for (int i = 1; i <= LAT + 4; i++) if (t + i < N) exp_ready[t + i] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (t + LAT + 1 + k < N) begin
        exp_rv[t + LAT + 1 + k]    = 1'b1;
        exp_data[t + LAT + 1 + k]  = mm[b | 9'(k)];
        exp_known[t + LAT + 1 + k] = mk[b | 9'(k)];
      end
    end
    for (int i = 1; i <= LAT + 4; i++) begin
      @(negedge clock);
      junk();
      if (rst_b2 && i == LAT + 3) begin
        do_reset();
        return;
      end
    end
    @(negedge clock);
    set_in(4'd0, 4'd0, 9'd0, 8'd0);
    m_rd++;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [31:0] d, input int abort_at,
                          input logic [3:0] bad, input bit sim, input bit rst_commit);
    int t;
    logic [8:0] b;
    b = a & 9'h1FC;
    set_in(sim ? 4'd1 : 4'd0, 4'd1, a, d[7:0]);
    @(posedge clock);
    t = ec;
    last_t = t;
    if (sim && t + 1 < N) exp_err[t + 1] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clock);
      if (k == abort_at) set_in(4'($urandom_range(0, 5)), bad, 9'($urandom), d[k*8 +: 8]);
      else set_in(4'($urandom_range(0, 5)), 4'(k + 1), 9'($urandom), d[k*8 +: 8]);
      @(posedge clock);
      if (k == abort_at) begin
        if (t + k + 1 < N) exp_err[t + k + 1] = 1'b1;
        @(negedge clock);
        set_in(4'd0, 4'd0, 9'd0, 8'd0);
        return;
      end
    end
    for (int i = 4; i <= 3 + LAT; i++) if (t + i < N) exp_ready[t + i] = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      @(negedge clock);
      junk();
      if (rst_commit && i == 1) begin
        do_reset();
        return;
      end
    end
    @(negedge clock);
    set_in(4'd0, 4'd0, 9'd0, 8'd0);
    for (int k = 0; k < 4; k++) begin
      mm[b | 9'(k)] = d[k*8 +: 8];
      mk[b | 9'(k)] = 1'b1;
    end
    m_wr++;
  endtask

  task automatic pin_read(input string name, input int t, input logic [31:0] blk);
    for (int k = 0; k < 4; k++) chk(name, 32'(smp_data[t + LAT + 1 + k]), 32'(blk[k*8 +: 8]));
    chk({name, "_rv_before"}, 32'(smp_rv[t + LAT]), 32'd0);
    chk({name, "_rdy_low"}, 32'(smp_ready[t + 1]), 32'd0);
    chk({name, "_rdy_low_end"}, 32'(smp_ready[t + LAT + 4]), 32'd0);
    chk({name, "_rdy_back"}, 32'(smp_ready[t + LAT + 5]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout cycle=%0d", ec);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int r;
    logic [8:0] a;
    clear_exp(0, N);
    for (int i = 0; i < 512; i++) begin
      mm[i] = 8'h00;
      mk[i] = 1'b0;
    end
    set_in(4'd0, 4'd0, 9'd0, 8'd0);
    run = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_ready", 32'(bus.ready_mem), 32'd1);
    chk("reset_rvalid", 32'(bus.rvalid_mem), 32'd0);
    chk("reset_err", 32'(bus.err_mem), 32'd0);
    #2;
    reset_n = 1'b1;
    @(negedge clock);

    // Read after write.
    do_write(9'h0A4, 32'h44332211, 0, 4'd0, 1'b0, 1'b0);
    t = last_t;
    idle_cycle();
    chk("wr_rdy_wdata", 32'(smp_ready[t + 3]), 32'd1);
    chk("wr_rdy_low_first", 32'(smp_ready[t + 4]), 32'd0);
    chk("wr_rdy_low_last", 32'(smp_ready[t + 3 + LAT]), 32'd0);
    chk("wr_rdy_back", 32'(smp_ready[t + 4 + LAT]), 32'd1);
    do_read(9'h0A4, 1'b0);
    t = last_t;
    idle_cycle();
    pin_read("rd_0A4", t, 32'h44332211);

    // Base alignment.
    do_write(9'h1F0, 32'hDDCCBBAA, 0, 4'd0, 1'b0, 1'b0);
    do_read(9'h1F3, 1'b0);
    t = last_t;
    idle_cycle();
    pin_read("rd_1F3", t, 32'hDDCCBBAA);

    // Aborted write: codes 1,2,0.
    do_write(9'h0A4, 32'h88776655, 2, 4'd0, 1'b0, 1'b0);
    t = last_t;
    idle_cycle();
    chk("abort_err", 32'(smp_err[t + 3]), 32'd1);
    chk("abort_err_before", 32'(smp_err[t + 2]), 32'd0);
    chk("abort_err_after", 32'(smp_err[t + 4]), 32'd0);
    do_read(9'h0A4, 1'b0);
    t = last_t;
    idle_cycle();
    pin_read("rd_after_abort", t, 32'h44332211);

    // Simultaneous start.
    do_write(9'h040, 32'h5A6B7C8D, 0, 4'd0, 1'b1, 1'b0);
    t = last_t;
    idle_cycle();
    chk("sim_err", 32'(smp_err[t + 1]), 32'd1);
    chk("sim_no_rvalid", 32'(smp_rv[t + LAT + 1]), 32'd0);
    do_read(9'h040, 1'b0);

    // Reset mid-read and mid-commit.
    do_read(9'h1F0, 1'b1);
    do_read(9'h1F0, 1'b0);
    t = last_t;
    idle_cycle();
    pin_read("rd_after_rst", t, 32'hDDCCBBAA);
    do_write(9'h0A4, 32'hFFEEDDCC, 0, 4'd0, 1'b0, 1'b1);
    do_read(9'h0A4, 1'b0);
    t = last_t;
    idle_cycle();
    pin_read("rd_after_rst_commit", t, 32'h44332211);

`ifdef MEMRESP_STATS_EN
    do_reset();
    chk("stats_rd_reset", 32'(rd_count), 32'd0);
    chk("stats_wr_reset", 32'(wr_count), 32'd0);
    do_read(9'h0A4, 1'b0);
    do_write(9'h0B0, 32'h01020304, 0, 4'd0, 1'b0, 1'b0);
    do_read(9'h0B0, 1'b0);
    do_write(9'h0B4, 32'h0A0B0C0D, 3, 4'd7, 1'b0, 1'b0);
    do_write(9'h0B8, 32'h11121314, 0, 4'd0, 1'b0, 1'b0);
    do_read(9'h0B8, 1'b0);
    idle_cycle();
    chk("stats_rd_count", 32'(rd_count), 32'd3);
    chk("stats_wr_count", 32'(wr_count), 32'd2);
`endif

    // Randomized traffic over a small address window.
    repeat (80) begin
      r = $urandom_range(0, 9);
      a = 9'h100 + 9'($urandom_range(0, 31));
      if (r < 5) begin
        do_read(a, 1'b0);
      end else if (r < 8) begin
        do_write(a, $urandom, 0, 4'd0, 1'b0, 1'b0);
      end else if (r == 8) begin
        int k;
        logic [3:0] bad;
        k = $urandom_range(1, 3);
        bad = 4'($urandom_range(0, 15));
        if (bad == 4'(k + 1)) bad = 4'd0;
        do_write(a, $urandom, k, bad, 1'b0, 1'b0);
      end else begin
        do_write(a, $urandom, 0, 4'd0, 1'b1, 1'b0);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();

`ifdef MEMRESP_STATS_EN
    chk("stats_rd_final", 32'(rd_count), 32'(m_rd));
    chk("stats_wr_final", 32'(wr_count), 32'(m_wr));
`endif

    repeat (3) idle_cycle();
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
